// File: rtl/cluster_header_seq.sv
// Cluster header: glitch-free gated cluster clock plus synchronised reset requests that are
// released to the cluster in ascending channel order with a programmable gap.
module cluster_header_seq #(
    parameter int unsigned NUM_RST      = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RELEASE_GAP  = 4,
    parameter bit          CKEN_RST_VAL = 1'b1
) (
    input  logic               gclk,
    input  logic               arst_l,
    input  logic               cluster_cken,
    input  logic [NUM_RST-1:0] grst_l_in,
    output logic               rclk,
    output logic [NUM_RST-1:0] cluster_rst_l,
    output logic               rst_done,
    input  logic               si,
    input  logic               se,
    output logic               so
);

    localparam int unsigned CHAIN = (NUM_RST + 1) * SYNC_STAGES;
    localparam int unsigned PW    = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam int unsigned CW    = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;

    // Request synchronisers occupy the low bits, cken synchroniser the top SYNC_STAGES bits.
    localparam logic [CHAIN-1:0] CHAIN_RST =
        {{SYNC_STAGES{CKEN_RST_VAL}}, {(NUM_RST * SYNC_STAGES){1'b0}}};

    typedef enum logic [1:0] {StReset, StArm, StGap, StDone} state_e;

    logic [CHAIN-1:0]   chain_q, chain_d;
    logic [NUM_RST:0]   sync_in;
    logic [NUM_RST-1:0] req_s;
    logic               en_s;
    logic               en_latch;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_RST-1:0] rst_q, rst_d;
    logic               done_q, done_d;
    logic               drop;
    logic [PW-1:0]      drop_idx;

    assign sync_in = {cluster_cken, grst_l_in};

    always_comb begin
        chain_d = chain_q;
        if (se) begin
            chain_d = {chain_q[CHAIN-2:0], si};
        end else begin
            for (int c = 0; c <= int'(NUM_RST); c++) begin
                for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                    if (s == 0) begin
                        chain_d[c * SYNC_STAGES] = sync_in[c];
                    end else begin
                        chain_d[c * SYNC_STAGES + s] = chain_q[c * SYNC_STAGES + s - 1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < int'(NUM_RST); c++) begin
            req_s[c] = chain_q[c * SYNC_STAGES + SYNC_STAGES - 1];
        end
    end

    assign en_s = chain_q[CHAIN-1];
    assign so   = chain_q[CHAIN-1];

    // Latch is opaque while gclk is high so an enable change can never truncate a pulse.
    always_latch begin
        if (!gclk && !se) begin
            en_latch = en_s;
        end
    end

    assign rclk = gclk & en_latch;

    // Lowest released channel whose request has dropped again.
    always_comb begin
        drop     = 1'b0;
        drop_idx = '0;
        for (int i = int'(NUM_RST) - 1; i >= 0; i--) begin
            if (rst_q[i] && !req_s[i]) begin
                drop     = 1'b1;
                drop_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (!se) begin
            if (state_q != StReset && drop) begin
                for (int k = 0; k < int'(NUM_RST); k++) begin
                    if (PW'(k) >= drop_idx) begin
                        rst_d[k] = 1'b0;
                    end
                end
                ptr_d   = drop_idx;
                done_d  = 1'b0;
                state_d = StArm;
            end else begin
                unique case (state_q)
                    StReset: state_d = StArm;
                    StArm: begin
                        if (req_s[ptr_q]) begin
                            rst_d[ptr_q] = 1'b1;
                            if (ptr_q == PW'(NUM_RST - 1)) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end else begin
                                ptr_d = ptr_q + 1'b1;
                                if (RELEASE_GAP != 0) begin
                                    cnt_d   = CW'(RELEASE_GAP - 1);
                                    state_d = StGap;
                                end
                            end
                        end
                    end
                    StGap: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            state_d = StArm;
                        end
                    end
                    StDone: state_d = StDone;
                    default: state_d = StReset;
                endcase
            end
        end
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            chain_q <= CHAIN_RST;
            state_q <= StReset;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    assign cluster_rst_l = rst_q;
    assign rst_done      = done_q;

endmodule

// File: tb/tb_cluster_header_seq.sv
// Scoreboard bench for cluster_header_seq: a default instance plus a four-channel, zero-gap one.
module tb_cluster_header_seq;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic       arst_l, arst2_l, cluster_cken, si, se;
    logic [2:0] grst_l_in;
    logic [3:0] grst2_l_in;
    logic       rclk, rst_done, so;
    logic [2:0] cluster_rst_l;
    logic       rclk2, rst_done2, so2;
    logic [3:0] cluster_rst2_l;

    cluster_header_seq dut (
        .gclk          (gclk),
        .arst_l        (arst_l),
        .cluster_cken  (cluster_cken),
        .grst_l_in     (grst_l_in),
        .rclk          (rclk),
        .cluster_rst_l (cluster_rst_l),
        .rst_done      (rst_done),
        .si            (si),
        .se            (se),
        .so            (so)
    );

    cluster_header_seq #(
        .NUM_RST     (4),
        .SYNC_STAGES (2),
        .RELEASE_GAP (0)
    ) dut_gap0 (
        .gclk          (gclk),
        .arst_l        (arst2_l),
        .cluster_cken  (1'b1),
        .grst_l_in     (grst2_l_in),
        .rclk          (rclk2),
        .cluster_rst_l (cluster_rst2_l),
        .rst_done      (rst_done2),
        .si            (1'b0),
        .se            (se),
        .so            (so2)
    );

    typedef struct {
        int cyc;
        int sel;   // 0 main {done,rst}, 1 gap0 {done,rst}, 2 rclk in high phase, 3 so
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   failures = 0;
    time  t_rise = 0;

    always @(posedge gclk) cyc <= cyc + 1;

    function automatic void do_check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            0:       return "main_rst";
            1:       return "gap0_rst";
            2:       return "rclk";
            default: return "scan_so";
        endcase
    endfunction

    function automatic int actual(input int sel);
        case (sel)
            0:       return int'({rst_done, cluster_rst_l});
            1:       return int'({rst_done2, cluster_rst2_l});
            2:       return int'(rclk);
            default: return int'(so);
        endcase
    endfunction

    function automatic void drain(input bit hi);
        exp_t keep[$];
        foreach (sb[i]) begin
            if (((sb[i].sel == 2) != hi) || sb[i].cyc > cyc) begin
                keep.push_back(sb[i]);
            end else if (sb[i].cyc == cyc) begin
                do_check(sel_name(sb[i].sel), actual(sb[i].sel), sb[i].val);
            end else begin
                do_check({sel_name(sb[i].sel), "_missed"}, -1, sb[i].val);
            end
        end
        sb = keep;
    endfunction

    function automatic void push(input int rel, input int sel, input int val);
        exp_t e;
        e.cyc = t0 + rel;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endfunction

    // Monitors: rclk sampled mid high phase, everything else on the falling edge.
    always @(posedge gclk) begin
        #2;
        drain(1'b1);
    end
    always @(negedge gclk) drain(1'b0);

    // Every rclk pulse must be a full gclk high phase.
    always @(posedge rclk) t_rise = $time;
    always @(negedge rclk) do_check("rclk_width", int'($time - t_rise), 5);

    task automatic goto(input int n);
        while (cyc < n) @(negedge gclk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        int          s;
        pat          = 16'b1011_0010_1110_0101;
        arst_l       = 1'b1;
        arst2_l      = 1'b1;
        cluster_cken = 1'b1;
        grst_l_in    = 3'b111;
        grst2_l_in   = 4'hf;
        si           = 1'b0;
        se           = 1'b0;
        #1;
        arst_l  = 1'b0;
        arst2_l = 1'b0;
        t0 = 0;
        push(1, 0, 0);
        push(1, 1, 0);
        push(2, 0, 0);

        // Default sequence and zero-gap sequence released together.
        goto(2);
        arst_l  = 1'b1;
        arst2_l = 1'b1;
        t0 = cyc;
        push(2, 0, 5'b00000);
        push(3, 0, 5'b00001);
        push(7, 0, 5'b00001);
        push(8, 0, 5'b00011);
        push(12, 0, 5'b00011);
        push(13, 0, 5'b01111);
        push(15, 0, 5'b01111);
        push(2, 1, 5'b00000);
        push(3, 1, 5'b00001);
        push(4, 1, 5'b00011);
        push(5, 1, 5'b00111);
        push(6, 1, 5'b11111);
        goto(t0 + 16);

        // Channel 2 held back, then re-assertion of channel 1 while done.
        arst_l    = 1'b0;
        grst_l_in = 3'b011;
        goto(cyc + 1);
        arst_l = 1'b1;
        t0 = cyc;
        push(8, 0, 5'b00011);
        push(13, 0, 5'b00011);
        push(22, 0, 5'b00011);
        push(23, 0, 5'b01111);
        push(32, 0, 5'b01111);
        push(33, 0, 5'b00001);
        push(35, 0, 5'b00001);
        push(36, 0, 5'b00011);
        push(40, 0, 5'b00011);
        push(41, 0, 5'b01111);
        goto(t0 + 20);
        grst_l_in = 3'b111;
        goto(t0 + 30);
        grst_l_in = 3'b101;
        goto(t0 + 33);
        grst_l_in = 3'b111;
        goto(t0 + 44);

        // Asynchronous reset in the middle of a gap, then a full restart.
        arst_l = 1'b0;
        goto(cyc + 1);
        arst_l = 1'b1;
        t0 = cyc;
        push(3, 0, 5'b00001);
        push(5, 0, 5'b00001);
        goto(t0 + 5);
        #2;
        arst_l = 1'b0;
        #1;
        do_check("async_rst", int'({rst_done, cluster_rst_l}), 0);
        goto(cyc + 2);
        arst_l = 1'b1;
        t0 = cyc;
        push(2, 0, 5'b00000);
        push(3, 0, 5'b00001);
        push(7, 0, 5'b00001);
        push(8, 0, 5'b00011);
        push(13, 0, 5'b01111);
        goto(t0 + 15);

        // Clock gate: disable in a low phase, then re-enable.
        t0 = cyc;
        cluster_cken = 1'b0;
        push(1, 2, 1);
        push(3, 2, 0);
        push(4, 2, 0);
        goto(t0 + 6);
        cluster_cken = 1'b1;
        push(10, 2, 1);
        goto(t0 + 12);

        // Scan shift through the 8-flop chain; FSM outputs must hold.
        s  = cyc;
        t0 = s;
        se = 1'b1;
        push(20, 0, 5'b01111);
        push(20, 1, 5'b11111);
        for (int k = 0; k < 16; k++) begin
            si = pat[15 - k];
            push(k + 8, 3, int'(pat[15 - k]));
            goto(s + k + 1);
        end
        si = 1'b0;
        goto(s + 24);
        se = 1'b0;

        goto(cyc + 4);
        foreach (sb[i]) do_check({sel_name(sb[i].sel), "_pending"}, -1, sb[i].val);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
